// File: rtl/axi_rd_arb_pkg.sv
// ============================================================================
// axi_rd_arb_pkg : shared constants and types for the AXI read arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_rd_arb_pkg;

    localparam int         c_NUM_REQ      = 3;

    localparam logic [1:0] c_REQ_ICACHE   = 2'd0;
    localparam logic [1:0] c_REQ_DCACHE   = 2'd1;
    localparam logic [1:0] c_REQ_UNCACHED = 2'd2;

    localparam logic [2:0] c_RD_TYPE_LINE = 3'b100;
    localparam logic [2:0] c_RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] c_RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] c_RD_TYPE_BYTE = 3'b000;

    localparam logic [2:0] c_ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] c_AR_BURST     = 2'b01;
    localparam logic [1:0] c_AR_LOCK      = 2'b00;
    localparam logic [3:0] c_AR_CACHE     = 4'b0000;
    localparam logic [2:0] c_AR_PROT      = 3'b000;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_AR_WAIT = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/arb_grant.sv
// ============================================================================
// arb_grant : one-hot grant by circular search starting at ptr_i
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_grant
    import axi_rd_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] grant_o
);

    // Fixed priority dcache > uncached > icache is the circular search from
    // dcache, so one search serves both the fixed and the round-robin modes.
    logic [2:0] w_sum;
    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < c_NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_i} + 3'(k);
            w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            if (!w_found && req_i[w_idx]) begin
                grant_o[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// axi_rd_arbiter : three-requester AXI read-address arbiter with R routing
// Option macro: AXI_RD_ARB_RR_EN selects round-robin instead of fixed priority
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic [2:0]  rd_req,
    input  logic [8:0]  rd_type,
    input  logic [95:0] rd_addr,
    output logic [2:0]  rd_rdy,
    output logic [2:0]  ret_valid,
    output logic        ret_last,
    output logic [31:0] ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    arb_state_e  state_q, state_d;
    logic [2:0]  busy_q, busy_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arid_q, arid_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;

    logic [2:0]  w_avail;
    logic [2:0]  w_grant;
    logic [2:0]  w_rdy;
    logic [2:0]  w_accept;
    logic [2:0]  w_ret_hit;
    logic [2:0]  w_clr;
    logic [1:0]  w_ptr;
    logic [1:0]  w_acc_idx;
    logic [31:0] w_sel_addr;
    logic [2:0]  w_sel_type;

    assign w_avail = rd_req & ~busy_q;

    arb_grant u_grant (
        .req_i   (w_avail),
        .ptr_i   (w_ptr),
        .grant_o (w_grant)
    );

`ifdef AXI_RD_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (|w_accept) begin
            ptr_d = (w_acc_idx == c_REQ_UNCACHED) ? c_REQ_ICACHE : w_acc_idx + 2'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr_q <= c_REQ_ICACHE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign w_ptr = ptr_q;
`else
    assign w_ptr = c_REQ_DCACHE;
`endif

    // Internal ready stays free of the reset net so no flop sees areset as data.
    assign w_rdy    = (state_q == ST_IDLE) ? (w_grant & ~busy_q) : 3'b000;
    assign w_accept = rd_req & w_rdy;

    always_comb begin
        w_acc_idx = c_REQ_ICACHE;
        if (w_accept[1]) begin
            w_acc_idx = c_REQ_DCACHE;
        end else if (w_accept[2]) begin
            w_acc_idx = c_REQ_UNCACHED;
        end
    end

    always_comb begin
        w_sel_addr = rd_addr[31:0];
        w_sel_type = rd_type[2:0];
        case (w_acc_idx)
            c_REQ_DCACHE: begin
                w_sel_addr = rd_addr[63:32];
                w_sel_type = rd_type[5:3];
            end
            c_REQ_UNCACHED: begin
                w_sel_addr = rd_addr[95:64];
                w_sel_type = rd_type[8:6];
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < c_NUM_REQ; i++) begin : g_ret
        assign w_ret_hit[i] = rvalid && (rid == 4'(i));
    end

    assign w_clr = rlast ? w_ret_hit : 3'b000;

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        busy_d   = (busy_q & ~w_clr) | w_accept;
        case (state_q)
            ST_IDLE: begin
                if (|w_accept) begin
                    state_d  = ST_AR_WAIT;
                    araddr_d = w_sel_addr;
                    arid_d   = {2'b00, w_acc_idx};
                    if (w_sel_type == c_RD_TYPE_LINE) begin
                        arlen_d  = 8'(BURST_LEN - 1);
                        arsize_d = c_ARSIZE_WORD;
                    end else begin
                        arlen_d  = 8'd0;
                        arsize_d = {1'b0, w_sel_type[1:0]};
                    end
                end
            end
            ST_AR_WAIT: begin
                if (arready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            busy_q   <= '0;
            araddr_q <= '0;
            arid_q   <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            araddr_q <= araddr_d;
            arid_q   <= arid_d;
            arlen_q  <= arlen_d;
            arsize_q <= arsize_d;
        end
    end

    assign rd_rdy    = areset ? 3'b000 : w_rdy;
    assign rready    = ~areset;
    assign ret_valid = areset ? 3'b000 : w_ret_hit;
    assign ret_last  = rlast;
    assign ret_data  = rdata;

    assign arvalid = (state_q == ST_AR_WAIT);
    assign araddr  = araddr_q;
    assign arid    = arid_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = c_AR_BURST;
    assign arlock  = c_AR_LOCK;
    assign arcache = c_AR_CACHE;
    assign arprot  = c_AR_PROT;

endmodule

`default_nettype wire

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: BURST_LEN, default 4, number of 32-bit beats in a cache-line refill; arlen for a line request = BURST_LEN-1.
REQ-002 aclk  in  1  single clock; all state changes on its rising edge.
REQ-003 areset  in  1  asynchronous, active-high reset.
REQ-004 rd_req  in  3  per-requester read request; bit 0 icache, bit 1 dcache, bit 2 uncached data.
REQ-005 rd_type  in  9  packed 3 bits per requester; 3'b100 line, 3'b010 word, 3'b001 half, 3'b000 byte.
REQ-006 rd_addr  in  96  packed 32-bit physical address per requester.
REQ-007 rd_rdy  out  3  per-requester acceptance; a request is accepted when rd_req[i] and rd_rdy[i] are both high in the same cycle.
REQ-008 ret_valid  out  3  per-requester return-beat valid.
REQ-009 ret_last  out  1  last beat of the current return.
REQ-010 ret_data  out  32  return data, broadcast to all requesters.
REQ-011 arid/araddr/arlen/arsize/arvalid  out  4/32/8/3/1  AXI read-address channel; arready  in  1.
REQ-012 arburst/arlock/arcache/arprot  out  2/2/4/3  constants 2'b01/0/0/0.
REQ-013 rid/rdata/rlast/rvalid  in  4/32/1/1  AXI read-data channel; rready  out  1.

Function
REQ-014 The arbiter SHALL be a two-state FSM: IDLE and AR_WAIT.
REQ-015 busy[i] SHALL be set when requester i's request is accepted, and SHALL clear on rvalid&rready&rlast with rid==i; each requester SHALL have at most one outstanding transaction.
REQ-016 rd_rdy[i] SHALL equal (state==IDLE) & grant[i] & ~busy[i], using registered busy.
REQ-017 grant SHALL be one-hot over the requesters with rd_req[i]&~busy[i]; fixed priority is dcache > uncached > icache.
REQ-018 On acceptance, araddr, arid=i, arlen and arsize SHALL be registered and the FSM SHALL go to AR_WAIT; arvalid SHALL be high from the next cycle onward.
REQ-019 For a line request, arlen=BURST_LEN-1 and arsize=3'b010; otherwise arlen=0 and arsize={1'b0, rd_type[1:0]}.
REQ-020 In AR_WAIT, arvalid and the AR fields SHALL stay stable until arready, then go to IDLE with arvalid low in the following cycle.
REQ-021 Throughput: at most one AR every 2 cycles, because acceptance happens only in IDLE.
REQ-022 rready SHALL be constantly 1 outside reset; ret_valid[i] = rvalid & (rid==i); ret_data = rdata; ret_last = rlast; the data path SHALL be combinational with 0 added latency.
REQ-023 A beat with rid>2 SHALL be consumed and dropped, with no busy change.
REQ-024 When busy[i] clears and rd_req[i] is high in the same cycle, the request SHALL NOT be accepted until the next cycle.
REQ-025 Return beats SHALL be routed while the FSM is in AR_WAIT for a different requester, so AR and R channels run independently.

Reset
REQ-026 While areset is high, the following SHALL hold: state=IDLE, busy=0, arvalid=0, araddr=0, arid=0, arlen=0, arsize=0, rready=0, rd_rdy=0, ret_valid=0.
REQ-027 Reset asserted mid-burst SHALL abandon the transaction; beats arriving after reset release SHALL route by rid with no busy change.

Configuration
REQ-028 With AXI_RD_ARB_RR_EN defined, grant SHALL be round-robin: the pointer starts at icache after reset, moves to one past the granted requester on each acceptance, and the search begins at the pointer.
REQ-029 Without AXI_RD_ARB_RR_EN, grant SHALL use the fixed priority in REQ-017 and no pointer register SHALL exist.

Structure
REQ-030 Shared package axi_rd_arb_pkg SHALL hold the requester index constants, the rd_type encodings, the FSM state encoding and the constant AR field values.
REQ-031 The grant logic SHALL be one sub-module, arb_grant (request vector plus pointer in, one-hot grant out), holding both the fixed-priority and the round-robin variant.

Verification
REQ-032 Reset, then icache line req addr 0x1c000000 -> rd_rdy[0] high; next cycle arvalid=1, arid=0, arlen=3, arsize=2; with 4 beats rid=0 -> ret_valid[0] x4 with ret_last on beat 4; busy[0] clears.
REQ-033 icache and dcache request in the same cycle (fixed priority) -> dcache accepted first with arid=1; icache accepted in the next IDLE cycle, arid=0.
REQ-034 With AXI_RD_ARB_RR_EN, all three requesting continuously with immediate arready -> grant order icache, dcache, uncached, icache.
REQ-035 Uncached half-word req addr 0xbfaf8002, arready held low 5 cycles -> arvalid, araddr and arsize=1 stable for all 5 cycles; single beat returns with ret_last=1.
REQ-036 busy[1] clears on rlast while dcache re-requests in the same cycle -> not accepted that cycle, accepted the next; a beat with rid=5 -> all ret_valid low and no state change.
